// File: rtl/uart_rx_engine.sv
// uart_rx_engine
//   Serial-to-parallel UART receiver. The RX line is passed through a two-flop
//   synchroniser (rx_s) and sampled at mid-bit. The receiver detects parity,
//   framing and overrun errors.
//   Frame layout: start, 7+EIGHT data bits (LSB first), optional parity, stop.
//   EIGHT/PEN/OHEL/baud_value are latched when a start edge is seen, so a
//   change made mid-frame takes effect on the next frame.
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   Defined  : every start/data/parity/stop decision is the majority of rx_s
//              taken at mid-2, mid and mid+2.
//   Undefined: a single rx_s sample is taken at the mid-bit point.
//   The port list is the same in both builds.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   baud_value   in   baud select, 0..11 (12..15 = 921600)
//   EIGHT        in   1 = 8 data bits, 0 = 7 data bits
//   PEN          in   parity bit present
//   OHEL         in   parity sense, 1 = odd, 0 = even
//   RX           in   serial line, idle high, asynchronous
//   read_strobe  in   consumer took rx_data; clears RXRDY and OVF
//   rx_data      out  received character (bit7 = 0 in 7-bit mode)
//   RXRDY        out  character available
//   PERR         out  parity error on the last completed frame
//   FERR         out  framing error on the last completed frame
//   OVF          out  sticky overrun
module uart_rx_engine #(
  parameter int CLK_FREQ_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] baud_value,
  input  logic       EIGHT,
  input  logic       PEN,
  input  logic       OHEL,
  input  logic       RX,
  input  logic       read_strobe,
  output logic [7:0] rx_data,
  output logic       RXRDY,
  output logic       PERR,
  output logic       FERR,
  output logic       OVF
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    LOAD   = 3'd5
  } state_t;

`ifdef UART_RX_MAJORITY_EN
  // The start decision is pushed out to mid+2. Because of that, every later bit
  // decision at count max-1 also lands two clocks after its true centre.
  localparam logic [19:0] START_OFS = 20'd2;
`else
  localparam logic [19:0] START_OFS = 20'd0;
`endif

  // Clocks per bit for each baud select (integer divide of the clock rate).
  function automatic logic [19:0] bit_time(input logic [3:0] sel);
    case (sel)
      4'd0:    bit_time = 20'(CLK_FREQ_HZ / 300);
      4'd1:    bit_time = 20'(CLK_FREQ_HZ / 1200);
      4'd2:    bit_time = 20'(CLK_FREQ_HZ / 2400);
      4'd3:    bit_time = 20'(CLK_FREQ_HZ / 4800);
      4'd4:    bit_time = 20'(CLK_FREQ_HZ / 9600);
      4'd5:    bit_time = 20'(CLK_FREQ_HZ / 19200);
      4'd6:    bit_time = 20'(CLK_FREQ_HZ / 38400);
      4'd7:    bit_time = 20'(CLK_FREQ_HZ / 57600);
      4'd8:    bit_time = 20'(CLK_FREQ_HZ / 115200);
      4'd9:    bit_time = 20'(CLK_FREQ_HZ / 230400);
      4'd10:   bit_time = 20'(CLK_FREQ_HZ / 460800);
      default: bit_time = 20'(CLK_FREQ_HZ / 921600);
    endcase
  endfunction

  // Expected parity bit: XOR of the data bits, inverted for odd sense.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    parity_bit = (^data) ^ odd;
  endfunction

  // In 7-bit mode only seven shifts happen, so the character still sits one
  // position high in the shift register.
  function automatic logic [7:0] align_data(input logic [7:0] shift, input logic eight);
    align_data = eight ? shift : {1'b0, shift[7:1]};
  endfunction

`ifdef UART_RX_MAJORITY_EN
  function automatic logic maj3(input logic a, input logic b, input logic c);
    maj3 = (a & b) | (a & c) | (b & c);
  endfunction
`endif

  state_t      state_r;
  logic [1:0]  rx_sync_r;
  logic        rx_prev_r;
  logic [19:0] cnt_r;
  logic [19:0] max_r;
  logic [2:0]  bit_idx_r;
  logic [7:0]  shift_r;
  logic        eight_r;
  logic        pen_r;
  logic        ohel_r;
  logic        perr_pend_r;
  logic        stop_bit_r;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0]  samp_r;
`endif

  logic        rx_s;
  logic [19:0] point_s;
  logic        at_point_s;
  logic        sample_s;
  logic        last_bit_s;

  assign rx_s = rx_sync_r[1];

  // Decision point and sampled bit value for the current state.
  always_comb begin
    point_s    = 20'd0;
    sample_s   = rx_s;
    last_bit_s = 1'b0;
    if (state_r == START) begin
      point_s = (max_r >> 1) + START_OFS;
    end else begin
      point_s = max_r - 20'd1;
    end
    at_point_s = (cnt_r == point_s);
`ifdef UART_RX_MAJORITY_EN
    sample_s = maj3(samp_r[1], samp_r[0], rx_s);
`else
    sample_s = rx_s;
`endif
    if (eight_r) begin
      last_bit_s = (bit_idx_r == 3'd7);
    end else begin
      last_bit_s = (bit_idx_r == 3'd6);
    end
  end

  // Synchroniser, frame FSM and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      rx_sync_r   <= 2'b11;
      rx_prev_r   <= 1'b1;
      cnt_r       <= 20'd0;
      max_r       <= 20'd0;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      eight_r     <= 1'b0;
      pen_r       <= 1'b0;
      ohel_r      <= 1'b0;
      perr_pend_r <= 1'b0;
      stop_bit_r  <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      samp_r      <= 2'b11;
`endif
      rx_data     <= 8'h00;
      RXRDY       <= 1'b0;
      PERR        <= 1'b0;
      FERR        <= 1'b0;
      OVF         <= 1'b0;
    end else begin
      rx_sync_r <= {rx_sync_r[0], RX};
      rx_prev_r <= rx_s;

      // Consumer read. A completion in LOAD below overrides RXRDY.
      if (read_strobe && RXRDY) begin
        RXRDY <= 1'b0;
        OVF   <= 1'b0;
      end

`ifdef UART_RX_MAJORITY_EN
      // Early majority samples at point-4 and point-2. The third sample is
      // rx_s at the decision point itself.
      if (state_r != IDLE && state_r != LOAD) begin
        if (cnt_r == point_s - 20'd4) samp_r[1] <= rx_s;
        if (cnt_r == point_s - 20'd2) samp_r[0] <= rx_s;
      end
`endif

      case (state_r)
        IDLE: begin
          // Edge (not level) detect, so a held break does not retrigger.
          if (rx_prev_r && !rx_s) begin
            state_r     <= START;
            cnt_r       <= 20'd0;
            max_r       <= bit_time(baud_value);
            eight_r     <= EIGHT;
            pen_r       <= PEN;
            ohel_r      <= OHEL;
            bit_idx_r   <= 3'd0;
            shift_r     <= 8'h00;
            perr_pend_r <= 1'b0;
          end
        end
        START: begin
          if (at_point_s) begin
            cnt_r <= 20'd0;
            if (!sample_s) begin
              state_r <= DATA;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            cnt_r <= cnt_r + 20'd1;
          end
        end
        DATA: begin
          if (at_point_s) begin
            cnt_r     <= 20'd0;
            shift_r   <= {sample_s, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
            if (last_bit_s) begin
              state_r <= pen_r ? PARITY : STOP;
            end
          end else begin
            cnt_r <= cnt_r + 20'd1;
          end
        end
        PARITY: begin
          if (at_point_s) begin
            cnt_r       <= 20'd0;
            perr_pend_r <= (sample_s != parity_bit(shift_r, ohel_r));
            state_r     <= STOP;
          end else begin
            cnt_r <= cnt_r + 20'd1;
          end
        end
        STOP: begin
          if (at_point_s) begin
            cnt_r      <= 20'd0;
            stop_bit_r <= sample_s;
            state_r    <= LOAD;
          end else begin
            cnt_r <= cnt_r + 20'd1;
          end
        end
        LOAD: begin
          rx_data <= align_data(shift_r, eight_r);
          RXRDY   <= 1'b1;
          PERR    <= perr_pend_r & pen_r;
          FERR    <= ~stop_bit_r;
          if (read_strobe) begin
            OVF <= 1'b0;
          end else if (RXRDY) begin
            OVF <= 1'b1;
          end
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 20'd0;
        end
      endcase
    end
  end

endmodule
